// File: rtl/uart_fp_multiplier.sv
// rtl/uart_fp_multiplier.sv - 8N1 UART receiver feeding an operand assembler and a 3-stage FP32 multiplier
//
// Ports:
//   i_Clock           system clock, rising edge
//   rst_n             asynchronous active-low reset
//   i_Rx_Serial       UART line, idles high
//   o_Rx_DV           one-cycle pulse per received byte
//   o_Rx_Byte         last received byte
//   o_A, o_B          operands (bytes 1-4 and 5-8 of a frame, MSB first)
//   o_Operands_Valid  one-cycle pulse when o_A/o_B are complete
//   o_Z               product A*B, held between results
//   o_Done            one-cycle pulse when o_Z is updated
module uart_fp_multiplier #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic        i_Clock,
    input  logic        rst_n,
    input  logic        i_Rx_Serial,
    output logic        o_Rx_DV,
    output logic [7:0]  o_Rx_Byte,
    output logic [31:0] o_A,
    output logic [31:0] o_B,
    output logic        o_Operands_Valid,
    output logic [31:0] o_Z,
    output logic        o_Done
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'((CLKS_PER_BIT - 1) / 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_CLEANUP
    } rx_state_t;

    // special-case classes carried down the multiplier pipeline
    localparam logic [1:0] K_NORM = 2'd0;
    localparam logic [1:0] K_ZERO = 2'd1;
    localparam logic [1:0] K_INF  = 2'd2;
    localparam logic [1:0] K_NAN  = 2'd3;

    // ---------------- UART receiver ----------------
    rx_state_t      state_q, state_d;
    logic           rx_meta_q, rx_meta_d;
    logic           rx_sync_q, rx_sync_d;
    logic [CW-1:0]  clk_cnt_q, clk_cnt_d;
    logic [2:0]     bit_idx_q, bit_idx_d;
    logic [7:0]     shift_q, shift_d;
    logic [7:0]     rx_byte_q, rx_byte_d;
    logic           rx_dv_q, rx_dv_d;

    // state register
    always_ff @(posedge i_Clock or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (!rx_sync_q) state_d = S_START;
            // mid-start-bit check rejects short low glitches
            S_START:   if (clk_cnt_q == CNT_HALF) state_d = rx_sync_q ? S_IDLE : S_DATA;
            S_DATA:    if (clk_cnt_q == CNT_LAST && bit_idx_q == 3'd7) state_d = S_STOP;
            S_STOP:    if (clk_cnt_q == CNT_LAST) state_d = S_CLEANUP;
            S_CLEANUP: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // datapath / output logic
    always_comb begin
        rx_meta_d = i_Rx_Serial;
        rx_sync_d = rx_meta_q;
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        rx_byte_d = rx_byte_q;
        rx_dv_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                clk_cnt_d = '0;
                bit_idx_d = '0;
            end
            S_START: clk_cnt_d = (clk_cnt_q == CNT_HALF) ? '0 : clk_cnt_q + 1'b1;
            S_DATA: begin
                if (clk_cnt_q == CNT_LAST) begin
                    clk_cnt_d          = '0;
                    shift_d[bit_idx_q] = rx_sync_q;
                    bit_idx_d          = bit_idx_q + 3'd1;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (clk_cnt_q == CNT_LAST) begin
                    clk_cnt_d = '0;
                    rx_dv_d   = 1'b1;
                    rx_byte_d = shift_q;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            default: clk_cnt_d = '0;
        endcase
    end

    always_ff @(posedge i_Clock or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            rx_byte_q <= '0;
            rx_dv_q   <= 1'b0;
        end else begin
            rx_meta_q <= rx_meta_d;
            rx_sync_q <= rx_sync_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            rx_byte_q <= rx_byte_d;
            rx_dv_q   <= rx_dv_d;
        end
    end

    // ---------------- operand assembler ----------------
    logic [2:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic        opv_q, opv_d;

    always_comb begin
        byte_cnt_d = byte_cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        opv_d      = 1'b0;
        if (rx_dv_q) begin
            byte_cnt_d = byte_cnt_q + 3'd1;
            if (!byte_cnt_q[2]) a_d = {a_q[23:0], rx_byte_q};
            else                b_d = {b_q[23:0], rx_byte_q};
            opv_d = (byte_cnt_q == 3'd7);
        end
    end

    always_ff @(posedge i_Clock or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt_q <= '0;
            a_q        <= '0;
            b_q        <= '0;
            opv_q      <= 1'b0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            opv_q      <= opv_d;
        end
    end

    // ---------------- FP32 multiplier ----------------
    // stage 1: unpack and classify
    logic        s1_vld_q, s1_vld_d, s1_sign_q, s1_sign_d;
    logic [1:0]  s1_kind_q, s1_kind_d;
    logic [7:0]  s1_ea_q, s1_ea_d, s1_eb_q, s1_eb_d;
    logic [23:0] s1_ma_q, s1_ma_d, s1_mb_q, s1_mb_d;
    // stage 2: multiply mantissas, add exponents
    logic        s2_vld_q, s2_vld_d, s2_sign_q, s2_sign_d;
    logic [1:0]  s2_kind_q, s2_kind_d;
    logic [8:0]  s2_esum_q, s2_esum_d;
    logic [47:0] s2_prod_q, s2_prod_d;
    // stage 3: normalize, round, pack
    logic [31:0] z_q, z_d;
    logic        done_q, done_d;

    logic        a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
    logic        norm, guard_b, round_b, sticky_b, round_up, carry;
    logic [22:0] frac_pre;
    logic [23:0] frac_rnd;
    logic [9:0]  e_tmp;
    logic [31:0] result;

    always_comb begin
        // subnormal inputs count as zero
        a_zero = (a_q[30:23] == 8'h00);
        b_zero = (b_q[30:23] == 8'h00);
        a_inf  = (a_q[30:23] == 8'hFF) && (a_q[22:0] == '0);
        b_inf  = (b_q[30:23] == 8'hFF) && (b_q[22:0] == '0);
        a_nan  = (a_q[30:23] == 8'hFF) && (a_q[22:0] != '0);
        b_nan  = (b_q[30:23] == 8'hFF) && (b_q[22:0] != '0);

        if (a_nan || b_nan || (a_zero && b_inf) || (a_inf && b_zero)) s1_kind_d = K_NAN;
        else if (a_inf || b_inf)                                       s1_kind_d = K_INF;
        else if (a_zero || b_zero)                                     s1_kind_d = K_ZERO;
        else                                                           s1_kind_d = K_NORM;

        // a newer operand set kills whatever is further down the pipe
        s1_vld_d  = opv_q;
        s1_sign_d = a_q[31] ^ b_q[31];
        s1_ea_d   = a_q[30:23];
        s1_eb_d   = b_q[30:23];
        s1_ma_d   = {1'b1, a_q[22:0]};
        s1_mb_d   = {1'b1, b_q[22:0]};

        s2_vld_d  = s1_vld_q && !opv_q;
        s2_sign_d = s1_sign_q;
        s2_kind_d = s1_kind_q;
        s2_esum_d = {1'b0, s1_ea_q} + {1'b0, s1_eb_q};
        s2_prod_d = s1_ma_q * s1_mb_q;

        // product of two [1,2) mantissas lies in [1,4); bit 47 means >= 2
        norm     = s2_prod_q[47];
        frac_pre = norm ? s2_prod_q[46:24] : s2_prod_q[45:23];
        guard_b  = norm ? s2_prod_q[23] : s2_prod_q[22];
        round_b  = norm ? s2_prod_q[22] : s2_prod_q[21];
        sticky_b = norm ? (|s2_prod_q[21:0]) : (|s2_prod_q[20:0]);
        round_up = guard_b && (round_b || sticky_b || frac_pre[0]);
        frac_rnd = {1'b0, frac_pre} + {23'd0, round_up};
        carry    = frac_rnd[23];  // all-ones fraction rounded up: fraction is now zero
        // biased exponent + 127, kept positive to avoid signed arithmetic
        e_tmp    = {1'b0, s2_esum_q} + {9'd0, norm} + {9'd0, carry};

        case (s2_kind_q)
            K_NAN:  result = 32'h7FC0_0000;
            K_INF:  result = {s2_sign_q, 8'hFF, 23'd0};
            K_ZERO: result = {s2_sign_q, 31'd0};
            default: begin
                if (e_tmp <= 10'd127)      result = {s2_sign_q, 31'd0};
                else if (e_tmp >= 10'd382) result = {s2_sign_q, 8'hFF, 23'd0};
                else                       result = {s2_sign_q, 8'(e_tmp - 10'd127), frac_rnd[22:0]};
            end
        endcase

        done_d = s2_vld_q && !s1_vld_q && !opv_q;
        z_d    = done_d ? result : z_q;
    end

    always_ff @(posedge i_Clock or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_sign_q <= 1'b0;
            s1_kind_q <= K_NORM;
            s1_ea_q   <= '0;
            s1_eb_q   <= '0;
            s1_ma_q   <= '0;
            s1_mb_q   <= '0;
            s2_vld_q  <= 1'b0;
            s2_sign_q <= 1'b0;
            s2_kind_q <= K_NORM;
            s2_esum_q <= '0;
            s2_prod_q <= '0;
            z_q       <= '0;
            done_q    <= 1'b0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_sign_q <= s1_sign_d;
            s1_kind_q <= s1_kind_d;
            s1_ea_q   <= s1_ea_d;
            s1_eb_q   <= s1_eb_d;
            s1_ma_q   <= s1_ma_d;
            s1_mb_q   <= s1_mb_d;
            s2_vld_q  <= s2_vld_d;
            s2_sign_q <= s2_sign_d;
            s2_kind_q <= s2_kind_d;
            s2_esum_q <= s2_esum_d;
            s2_prod_q <= s2_prod_d;
            z_q       <= z_d;
            done_q    <= done_d;
        end
    end

    assign o_Rx_DV          = rx_dv_q;
    assign o_Rx_Byte        = rx_byte_q;
    assign o_A              = a_q;
    assign o_B              = b_q;
    assign o_Operands_Valid = opv_q;
    assign o_Z              = z_q;
    assign o_Done           = done_q;

endmodule

// File: tb/tb_uart_fp_multiplier.sv
// tb/tb_uart_fp_multiplier.sv - scoreboard bench for uart_fp_multiplier
module tb_uart_fp_multiplier;

    localparam int CPB = 31;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic        rx_dv, opv, done;
    logic [7:0]  rx_byte;
    logic [31:0] a_o, b_o, z_o;

    uart_fp_multiplier #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clock(clk), .rst_n(rst_n), .i_Rx_Serial(rx),
        .o_Rx_DV(rx_dv), .o_Rx_Byte(rx_byte), .o_A(a_o), .o_B(b_o),
        .o_Operands_Valid(opv), .o_Z(z_o), .o_Done(done)
    );

    always #50 clk = ~clk;

    int checks = 0;
    int errors = 0;
    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]  exp_bytes[$];
    logic [63:0] exp_ab[$];
    logic [31:0] exp_z[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // reference FP32 multiply: flush-to-zero inputs/outputs, round-to-nearest-even
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic   s;
        int     ea, eb, e, sh;
        longint p, q, rem, half;
        logic [63:0] qv;
        logic a_z, b_z, a_i, b_i, a_n, b_n;
        s   = a[31] ^ b[31];
        ea  = int'(a[30:23]);
        eb  = int'(b[30:23]);
        a_z = (ea == 0);   b_z = (eb == 0);
        a_i = (ea == 255) && (a[22:0] == 0);
        b_i = (eb == 255) && (b[22:0] == 0);
        a_n = (ea == 255) && (a[22:0] != 0);
        b_n = (eb == 255) && (b[22:0] != 0);
        if (a_n || b_n || (a_z && b_i) || (a_i && b_z)) return 32'h7FC00000;
        if (a_i || b_i) return {s, 8'hFF, 23'd0};
        if (a_z || b_z) return {s, 31'd0};
        // value = p * 2^(ea+eb-254-46)
        p  = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
        e  = ea + eb - 127;
        sh = 23;
        if (p >= (longint'(1) << 47)) begin sh = 24; e++; end
        q    = p >> sh;
        rem  = p - (q << sh);
        half = longint'(1) << (sh - 1);
        qv   = q;
        if (rem > half || (rem == half && qv[0])) q++;
        if (q == (longint'(1) << 24)) begin q = q >> 1; e++; end
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0)   return {s, 31'd0};
        qv = q;
        return {s, 8'(e), qv[22:0]};
    endfunction

    // monitor: pops expectations whenever the DUT presents an output
    initial begin
        longint last_dv = -10, last_opv = -10;
        logic [31:0] prev_z = '0;
        logic [63:0] e64;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (rx_dv) begin
                    last_dv = cyc;
                    if (exp_bytes.size() == 0) check("unexpected_rx_dv", {56'd0, rx_byte}, 64'hDEAD);
                    else check("rx_byte", {56'd0, rx_byte}, {56'd0, exp_bytes.pop_front()});
                end
                if (opv) begin
                    last_opv = cyc;
                    check("opv_latency", 64'(cyc - last_dv), 64'd1);
                    if (exp_ab.size() == 0) check("unexpected_opv", {a_o, b_o}, 64'hDEAD);
                    else begin
                        e64 = exp_ab.pop_front();
                        check("operand_a", {32'd0, a_o}, {32'd0, e64[63:32]});
                        check("operand_b", {32'd0, b_o}, {32'd0, e64[31:0]});
                    end
                end
                if (done) begin
                    check("done_latency", 64'(cyc - last_opv), 64'd3);
                    if (exp_z.size() == 0) check("unexpected_done", {32'd0, z_o}, 64'hDEAD);
                    else check("product_z", {32'd0, z_o}, {32'd0, exp_z.pop_front()});
                end
                if (z_o !== prev_z) check("z_changes_only_on_done", {63'd0, done}, 64'd1);
            end
            prev_z = z_o;
        end
    end

    task automatic send_byte(input logic [7:0] d);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [31:0] a, input logic [31:0] b, input logic [31:0] z);
        logic [63:0] f;
        f = {a, b};
        for (int i = 7; i >= 0; i--) exp_bytes.push_back(f[i*8 +: 8]);
        exp_ab.push_back(f);
        exp_z.push_back(z);
        for (int i = 7; i >= 0; i--) send_byte(f[i*8 +: 8]);
        repeat (CPB) @(negedge clk);
    endtask

    function automatic logic [31:0] rand_op();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 7) != 0) r[30:23] = 8'($urandom_range(90, 164));
        return r;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_dv"},   {63'd0, rx_dv}, 64'd0);
        check({tag, "_rx_byte"}, {56'd0, rx_byte}, 64'd0);
        check({tag, "_a_b"},     {a_o, b_o}, 64'd0);
        check({tag, "_opv"},     {63'd0, opv}, 64'd0);
        check({tag, "_z_done"},  {31'd0, z_o, done}, 64'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        repeat (5) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2 * CPB) @(negedge clk);

        send_frame(32'h40600000, 32'h40000000, 32'h40E00000);
        send_frame(32'h80000000, 32'h40400000, 32'h80000000);
        send_frame(32'h7F000000, 32'h7F000000, 32'h7F800000);
        send_frame(32'h7FC00001, 32'h3F800000, 32'h7FC00000);
        send_frame(32'h00000000, 32'h7F800000, 32'h7FC00000);
        send_frame(32'h3F800001, 32'h3F800001, 32'h3F800002);

        // short low glitch: no byte, counter must stay aligned for the next frame
        rx = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        send_frame(32'h3FC00000, 32'hC0200000, 32'hC0700000);

        // reset in the middle of byte 4 of a frame
        for (int i = 0; i < 3; i++) begin
            exp_bytes.push_back(8'hA0 + 8'(i));
            send_byte(8'hA0 + 8'(i));
        end
        rx = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        rst_n = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("midframe_reset");
        rst_n = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        ra = rand_op();
        rb = rand_op();
        send_frame(ra, rb, ref_mul(ra, rb));

        for (int n = 0; n < 10; n++) begin
            ra = rand_op();
            rb = rand_op();
            send_frame(ra, rb, ref_mul(ra, rb));
        end

        for (int i = 0; i < 4000 && (exp_bytes.size() + exp_ab.size() + exp_z.size()) != 0; i++)
            @(negedge clk);
        check("pending_bytes", 64'(exp_bytes.size()), 64'd0);
        check("pending_operands", 64'(exp_ab.size()), 64'd0);
        check("pending_products", 64'(exp_z.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
